// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: baud divider derivation, FSM state encodings and
// character width, used by both the receive and transmit stages.
package uart_defs;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int calc_baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int uart_bps);
    return calc_baud_cnt_max(clk_freq, uart_bps) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen per input so that reset release never looks like an edge.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      dout <= RESET_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a 1-deep valid/ready holding
// register, and single-cycle framing-error and overrun pulses.
module uart_rx
  import uart_defs::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int HALF_CNT     = calc_half_cnt(CLK_FREQ, UART_BPS);
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 line_sync;
  logic                 line_prev;
  logic                 start_edge;
  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_tick;
  logic                 stop_tick;
  logic                 stop_good;
  logic                 stop_bad;
  logic                 hold_free;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (uart_rxd),
    .dout (line_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_prev <= 1'b1;
    end else begin
      line_prev <= line_sync;
    end
  end

  // Only a true high-to-low transition starts a frame, so a held-low break
  // cannot retrigger after its framing error.
  assign start_edge = line_prev & ~line_sync;

  always_comb begin
    bit_tick = 1'b0;
    if (state == ST_START) begin
      bit_tick = (baud_cnt == CNT_HALF);
    end else begin
      bit_tick = (baud_cnt == CNT_LAST);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_next = line_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick && (bit_idx == IDX_LAST)) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Restarting the count on every state change puts the START sample at
  // mid-bit and every later sample one full bit period after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if ((state_next != state) || (state == ST_IDLE)) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if ((state == ST_DATA) && bit_tick) begin
      shift_reg <= {line_sync, shift_reg[DATA_BITS-1:1]};
      bit_idx   <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
    end else if (state == ST_IDLE) begin
      bit_idx <= '0;
    end
  end

  assign stop_tick = (state == ST_STOP) && bit_tick;
  assign stop_good = stop_tick & line_sync;
  assign stop_bad  = stop_tick & ~line_sync;
  assign hold_free = ~rx_valid | rx_ready;

  // A byte arriving while the consumer reads the old one is loaded in the
  // same edge, so rx_valid stays high with the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= stop_bad;
      rx_overrun   <= stop_good & ~hold_free;
      if (stop_good && hold_free) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: drives 8N1 frames on uart_rxd
// and compares received bytes and status pulses against hand-derived values.
module tb_uart_rx;

  localparam int CLK_FREQ = 11_520_000;
  localparam int UART_BPS = 115200;
  localparam int BIT      = CLK_FREQ / UART_BPS;
  localparam int HALF     = BIT / 2;
  localparam int LAT_MAX  = 3 + (BIT * 19) / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [7:0] got_q[$];
  int         valid_rise_q[$];
  int         err_runs[$];
  int         ov_runs[$];
  int         busy_low_runs[$];
  logic       valid_d = 1'b0;
  int         err_len = 0;
  int         ov_len = 0;
  int         busy_low_len = 0;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: accepted bytes, rx_valid rise times and pulse widths.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid && !valid_d) valid_rise_q.push_back(cyc);
    valid_d <= rx_valid;
    if (rx_frame_err) err_len <= err_len + 1;
    else if (err_len > 0) begin
      err_runs.push_back(err_len);
      err_len <= 0;
    end
    if (rx_overrun) ov_len <= ov_len + 1;
    else if (ov_len > 0) begin
      ov_runs.push_back(ov_len);
      ov_len <= 0;
    end
    if (!rx_busy) busy_low_len <= busy_low_len + 1;
    else if (busy_low_len > 0) begin
      busy_low_runs.push_back(busy_low_len);
      busy_low_len <= 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    uart_rxd = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      step(BIT);
    end
    uart_rxd = stop_bit;
    step(BIT);
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %02h exp 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", rx_busy); end
    checks++; if ({rx_frame_err, rx_overrun} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b exp 00", {rx_frame_err, rx_overrun}); end
    rst = 1'b0;
    step(2 * BIT);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy got %b exp 0", rx_busy); end
  endtask

  task automatic test_basic();
    int base, vr0, e0, o0, s55, lat;
    base = got_q.size(); vr0 = valid_rise_q.size(); e0 = err_runs.size(); o0 = ov_runs.size();
    rx_ready = 1'b1;
    send_byte(8'h55, 1'b1);
    s55 = start_cyc;
    send_byte(8'hA3, 1'b1);
    step(BIT);
    checks++; if (got_q.size() !== base + 2) begin errors++; $display("[TB] FAIL basic_count got %0d exp %0d", got_q.size() - base, 2); end
    else begin
      checks++; if (got_q[base] !== 8'h55) begin errors++; $display("[TB] FAIL basic_byte0 got %02h exp 55", got_q[base]); end
      checks++; if (got_q[base+1] !== 8'hA3) begin errors++; $display("[TB] FAIL basic_byte1 got %02h exp a3", got_q[base+1]); end
    end
    checks++; if (err_runs.size() - e0 !== 0) begin errors++; $display("[TB] FAIL basic_frame_err got %0d exp 0", err_runs.size() - e0); end
    checks++; if (ov_runs.size() - o0 !== 0) begin errors++; $display("[TB] FAIL basic_overrun got %0d exp 0", ov_runs.size() - o0); end
    lat = (valid_rise_q.size() > vr0) ? valid_rise_q[vr0] - s55 : -1;
    checks++; if (lat > LAT_MAX || lat < 9 * BIT) begin errors++; $display("[TB] FAIL basic_latency got %0d exp %0d..%0d", lat, 9 * BIT, LAT_MAX); end
  endtask

  task automatic test_back_to_back();
    int base, b0;
    base = got_q.size();
    send_byte(8'h00, 1'b1);
    b0 = busy_low_runs.size();
    send_byte(8'hFF, 1'b1);
    step(BIT);
    checks++; if (got_q.size() !== base + 2) begin errors++; $display("[TB] FAIL b2b_count got %0d exp 2", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] !== 8'h00) begin errors++; $display("[TB] FAIL b2b_byte0 got %02h exp 00", got_q[base]); end
      checks++; if (got_q[base+1] !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_byte1 got %02h exp ff", got_q[base+1]); end
    end
    checks++;
    if (busy_low_runs.size() <= b0) begin errors++; $display("[TB] FAIL b2b_busy_gap got none exp <= %0d", HALF + 5); end
    else if (busy_low_runs[b0] > HALF + 5) begin errors++; $display("[TB] FAIL b2b_busy_gap got %0d exp <= %0d", busy_low_runs[b0], HALF + 5); end
  endtask

  task automatic test_glitch();
    int base, e0;
    base = got_q.size(); e0 = err_runs.size();
    uart_rxd = 1'b0;
    step(HALF / 2);
    uart_rxd = 1'b1;
    step(2 * BIT);
    checks++; if (got_q.size() !== base) begin errors++; $display("[TB] FAIL glitch_no_byte got %0d exp 0", got_q.size() - base); end
    checks++; if (err_runs.size() !== e0) begin errors++; $display("[TB] FAIL glitch_no_err got %0d exp 0", err_runs.size() - e0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy got %b exp 0", rx_busy); end
    send_byte(8'h3C, 1'b1);
    step(BIT);
    checks++; if (got_q.size() !== base + 1 || got_q[got_q.size()-1] !== 8'h3C) begin errors++; $display("[TB] FAIL glitch_next_byte got %02h (n=%0d) exp 3c", got_q[got_q.size()-1], got_q.size() - base); end
  endtask

  task automatic test_frame_err();
    int base, e0;
    base = got_q.size(); e0 = err_runs.size();
    send_byte(8'h81, 1'b0);
    step(BIT);
    checks++; if (err_runs.size() - e0 !== 1) begin errors++; $display("[TB] FAIL ferr_count got %0d exp 1", err_runs.size() - e0); end
    else begin
      checks++; if (err_runs[e0] !== 1) begin errors++; $display("[TB] FAIL ferr_width got %0d exp 1", err_runs[e0]); end
    end
    checks++; if (got_q.size() !== base || rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL ferr_no_byte got n=%0d valid=%b exp n=0 valid=0", got_q.size() - base, rx_valid); end
    uart_rxd = 1'b0;
    step(30 * BIT);
    uart_rxd = 1'b1;
    step(2 * BIT);
    checks++; if (err_runs.size() - e0 !== 2) begin errors++; $display("[TB] FAIL break_err_count got %0d exp 2", err_runs.size() - e0); end
    checks++; if (got_q.size() !== base) begin errors++; $display("[TB] FAIL break_no_byte got %0d exp 0", got_q.size() - base); end
  endtask

  task automatic test_overrun();
    int base, o0;
    base = got_q.size(); o0 = ov_runs.size();
    rx_ready = 1'b0;
    send_byte(8'h12, 1'b1);
    step(BIT);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin errors++; $display("[TB] FAIL ovr_hold got valid=%b data=%02h exp valid=1 data=12", rx_valid, rx_data); end
    send_byte(8'h34, 1'b1);
    step(BIT);
    checks++; if (ov_runs.size() - o0 !== 1) begin errors++; $display("[TB] FAIL ovr_pulse_count got %0d exp 1", ov_runs.size() - o0); end
    else begin
      checks++; if (ov_runs[o0] !== 1) begin errors++; $display("[TB] FAIL ovr_pulse_width got %0d exp 1", ov_runs[o0]); end
    end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin errors++; $display("[TB] FAIL ovr_keep_old got valid=%b data=%02h exp valid=1 data=12", rx_valid, rx_data); end
    rx_ready = 1'b1;
    step(1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain_valid got %b exp 0", rx_valid); end
    checks++; if (got_q.size() !== base + 1 || got_q[base] !== 8'h12) begin errors++; $display("[TB] FAIL ovr_drain_byte got n=%0d exp one byte 12", got_q.size() - base); end
    send_byte(8'h56, 1'b1);
    step(BIT);
    checks++; if (got_q.size() !== base + 2 || got_q[got_q.size()-1] !== 8'h56) begin errors++; $display("[TB] FAIL ovr_next_byte got %02h (n=%0d) exp 56", got_q[got_q.size()-1], got_q.size() - base); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] frame;
    int base;
    frame = {1'b1, 8'hC7, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rxd = frame[k];
      if (k == 5) begin
        step(HALF);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before got %b exp 1", rx_busy); end
        rst = 1'b1;
        #1;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy got %b exp 0", rx_busy); end
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_outputs got data=%02h valid=%b exp 00/0", rx_data, rx_valid); end
        step(BIT - HALF);
      end else begin
        step(BIT);
      end
    end
    uart_rxd = 1'b1;
    step(2);
    rst = 1'b0;
    step(2 * BIT);
    base = got_q.size();
    send_byte(8'h5A, 1'b1);
    step(BIT);
    checks++; if (got_q.size() !== base + 1 || got_q[got_q.size()-1] !== 8'h5A) begin errors++; $display("[TB] FAIL mid_after_byte got %02h (n=%0d) exp 5a", got_q[got_q.size()-1], got_q.size() - base); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
